// File: rtl/comb_sweep_ctrl_if.sv
// Bundle between the sweep controller and the four combinational variants under test.
// COMB_SWEEP_CAPTURE_EN adds the first-failure capture signals.
interface comb_sweep_ctrl_if;
    logic       start;
    logic [3:0] abcd;
    logic       y_str;
    logic       y_dataflow;
    logic       y_behavior;
    logic       y_prim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
    logic [3:0] err_mask;
`ifdef COMB_SWEEP_CAPTURE_EN
    logic       fail_vld;
    logic [3:0] fail_vec;
    logic [3:0] fail_y;
`endif

    modport master (
        input  start, y_str, y_dataflow, y_behavior, y_prim,
        output abcd, busy, done, pass, err_cnt, err_mask
`ifdef COMB_SWEEP_CAPTURE_EN
        , output fail_vld, fail_vec, fail_y
`endif
    );

    modport slave (
        output start, y_str, y_dataflow, y_behavior, y_prim,
        input  abcd, busy, done, pass, err_cnt, err_mask
`ifdef COMB_SWEEP_CAPTURE_EN
        , input fail_vld, fail_vec, fail_y
`endif
    );
endinterface

// File: rtl/comb_sweep_ctrl.sv
// Clocked self-checking sweep of all 16 {A,B,C,D} vectors across four variants.
// Optional first-failure capture when COMB_SWEEP_CAPTURE_EN is defined.
module comb_sweep_ctrl #(
    parameter int          SETTLE = 2,
    parameter logic [15:0] TRUTH  = 16'h6996
) (
    input  logic                  clk,
    input  logic                  rst,
    comb_sweep_ctrl_if.master     bus
);
    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] vec;
    logic [3:0] scnt;
    logic [3:0] y;
    logic [3:0] miss;

    assign y    = {bus.y_str, bus.y_dataflow, bus.y_behavior, bus.y_prim};
    assign miss = y ^ {4{TRUTH[vec]}};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_APPLY;
            S_APPLY:  state_nxt = S_SETTLE;
            S_SETTLE: if (scnt == 4'd0) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (vec == 4'd15) ? S_DONE : S_APPLY;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // abcd is loaded on the edge that enters APPLY, so it is valid for the whole vector period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            vec          <= 4'd0;
            scnt         <= 4'd0;
            bus.abcd     <= 4'd0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.pass     <= 1'b0;
            bus.err_cnt  <= 5'd0;
            bus.err_mask <= 4'd0;
`ifdef COMB_SWEEP_CAPTURE_EN
            bus.fail_vld <= 1'b0;
            bus.fail_vec <= 4'd0;
            bus.fail_y   <= 4'd0;
`endif
        end else begin
            state    <= state_nxt;
            bus.busy <= (state_nxt != S_IDLE);
            bus.done <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        vec          <= 4'd0;
                        bus.abcd     <= 4'd0;
                        bus.pass     <= 1'b0;
                        bus.err_cnt  <= 5'd0;
                        bus.err_mask <= 4'd0;
`ifdef COMB_SWEEP_CAPTURE_EN
                        bus.fail_vld <= 1'b0;
                        bus.fail_vec <= 4'd0;
                        bus.fail_y   <= 4'd0;
`endif
                    end
                end
                S_APPLY:  scnt <= 4'(SETTLE - 1);
                S_SETTLE: if (scnt != 4'd0) scnt <= scnt - 4'd1;
                S_CHECK: begin
                    bus.err_mask <= bus.err_mask | miss;
                    if ((|miss) && (bus.err_cnt != 5'd16))
                        bus.err_cnt <= bus.err_cnt + 5'd1;
`ifdef COMB_SWEEP_CAPTURE_EN
                    if ((|miss) && !bus.fail_vld) begin
                        bus.fail_vld <= 1'b1;
                        bus.fail_vec <= vec;
                        bus.fail_y   <= y;
                    end
`endif
                    if (vec != 4'd15) begin
                        vec      <= vec + 4'd1;
                        bus.abcd <= vec + 4'd1;
                    end
                end
                S_DONE:   bus.pass <= (bus.err_cnt == 5'd0);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Randomized bench for comb_sweep_ctrl: two instances (SETTLE=2 and SETTLE=5) driven by
// truth-table variant models, results compared against a per-vector reference model.
module tb_comb_sweep_ctrl;
    localparam logic [15:0] TT = 16'h6996;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;
    logic [15:0] vt [4];     // variant truth tables: [3]=str [2]=dataflow [1]=behavior [0]=prim

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    comb_sweep_ctrl_if if2 ();
    comb_sweep_ctrl_if if5 ();

    assign if2.start      = start & ~sel;
    assign if5.start      = start & sel;
    assign if2.y_str      = vt[3][if2.abcd];
    assign if2.y_dataflow = vt[2][if2.abcd];
    assign if2.y_behavior = vt[1][if2.abcd];
    assign if2.y_prim     = vt[0][if2.abcd];
    assign if5.y_str      = vt[3][if5.abcd];
    assign if5.y_dataflow = vt[2][if5.abcd];
    assign if5.y_behavior = vt[1][if5.abcd];
    assign if5.y_prim     = vt[0][if5.abcd];

    comb_sweep_ctrl #(.SETTLE(2), .TRUTH(TT)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    comb_sweep_ctrl #(.SETTLE(5), .TRUTH(TT)) u_dut5 (.clk(clk), .rst(rst), .bus(if5));

    logic       o_busy, o_done, o_pass;
    logic [3:0] o_abcd, o_mask;
    logic [4:0] o_cnt;
    always_comb begin
        o_busy = sel ? if5.busy     : if2.busy;
        o_done = sel ? if5.done     : if2.done;
        o_pass = sel ? if5.pass     : if2.pass;
        o_abcd = sel ? if5.abcd     : if2.abcd;
        o_mask = sel ? if5.err_mask : if2.err_mask;
        o_cnt  = sel ? if5.err_cnt  : if2.err_cnt;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk the 16 vectors and classify each variant against the golden table.
    task automatic model(output int cnt, output int mask, output int fvld, output int fvec);
        cnt = 0; mask = 0; fvld = 0; fvec = 0;
        for (int i = 0; i < 16; i++) begin
            bit any = 0;
            for (int k = 0; k < 4; k++) begin
                if (vt[k][i] != TT[i]) begin
                    mask = mask | (1 << k);
                    any = 1;
                end
            end
            if (any) begin
                cnt++;
                if (fvld == 0) begin fvld = 1; fvec = i; end
            end
        end
    endtask

    task automatic sweep(input string nm, input bit extra, input bit hold);
        int s, per, l0, lim;
        int done_cyc, done_n, busy_n, abcd_bad, b1, b2;
        int r_cnt, r_mask, r_pass;
        int e_cnt, e_mask, e_fv, e_fvec;
        int wait_n;
        bit seen;
`ifdef COMB_SWEEP_CAPTURE_EN
        int r_fv, r_fvec, r_fy, e_fy;
`endif
        s = sel ? 5 : 2;
        per = 16 * (s + 2);
        l0 = per + 1;
        lim = l0 + 2;
        done_cyc = 0; done_n = 0; busy_n = 0; abcd_bad = 0; b1 = 0; b2 = 0;
        r_cnt = 0; r_mask = 0; r_pass = 0;
        model(e_cnt, e_mask, e_fv, e_fvec);
`ifdef COMB_SWEEP_CAPTURE_EN
        r_fv = 0; r_fvec = 0; r_fy = 0;
        e_fy = {vt[3][e_fvec], vt[2][e_fvec], vt[1][e_fvec], vt[0][e_fvec]};
`endif
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= lim; c++) begin
            if (!hold) start = (extra && c <= l0 && $urandom_range(0, 3) == 0);
            if (c <= l0 + 1) begin
                if (o_done) begin
                    done_n++;
                    if (done_cyc == 0) done_cyc = c;
                end
                if (o_busy) busy_n++;
            end
            if (c <= per && o_abcd != 4'((c - 1) / (s + 2))) abcd_bad++;
            if (c == l0 + 1) begin
                b1 = o_busy;
                r_cnt = o_cnt; r_mask = o_mask; r_pass = o_pass;
`ifdef COMB_SWEEP_CAPTURE_EN
                r_fv   = sel ? if5.fail_vld : if2.fail_vld;
                r_fvec = sel ? if5.fail_vec : if2.fail_vec;
                r_fy   = sel ? if5.fail_y   : if2.fail_y;
`endif
            end
            if (c == l0 + 2) b2 = (o_busy && o_abcd == 4'd0);
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, " done_cycle"}, done_cyc, l0);
        chk({nm, " done_pulses"}, done_n, 1);
        chk({nm, " busy_cycles"}, busy_n, l0);
        chk({nm, " abcd_steps_bad"}, abcd_bad, 0);
        chk({nm, " err_cnt"}, r_cnt, e_cnt);
        chk({nm, " err_mask"}, r_mask, e_mask);
        chk({nm, " pass"}, r_pass, (e_cnt == 0) ? 1 : 0);
`ifdef COMB_SWEEP_CAPTURE_EN
        chk({nm, " fail_vld"}, r_fv, e_fv);
        if (e_fv != 0) begin
            chk({nm, " fail_vec"}, r_fvec, e_fvec);
            chk({nm, " fail_y"}, r_fy, e_fy);
        end
`endif
        if (hold) begin
            chk({nm, " idle_gap_busy"}, b1, 0);
            chk({nm, " restart_apply"}, b2, 1);
            seen = 0;
            wait_n = 0;
            while (!seen && wait_n < per + 10) begin
                if (o_done) seen = 1;
                wait_n++;
                @(negedge clk);
            end
            chk({nm, " second_sweep_done"}, seen, 1);
            repeat (2) @(negedge clk);
        end else begin
            chk({nm, " idle_after"}, b2, 0);
        end
    endtask

    task automatic set_clean();
        for (int k = 0; k < 4; k++) vt[k] = TT;
    endtask

    initial begin
        int n;
        bit seen;
        set_clean();
        #12;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_abcd", o_abcd, 0);
        chk("rst_cnt", o_cnt, 0);
        chk("rst_mask", o_mask, 0);
        chk("rst_pass", o_pass, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        sel = 0; set_clean();
        sweep("clean", 0, 0);

        set_clean(); vt[0] = 16'h0000;
        sweep("prim_sa0", 0, 0);

        sel = 1; set_clean(); vt[3] = ~TT;
        sweep("str_inv_s5", 0, 0);

        sel = 0; set_clean(); vt[1] = TT ^ 16'h0220;
        sweep("beh_5_9", 0, 0);

        for (int it = 0; it < 6; it++) begin
            sel = it[0];
            for (int k = 0; k < 4; k++)
                vt[k] = ($urandom_range(0, 1) != 0) ? TT : (TT ^ 16'($urandom & $urandom));
            sweep("rand", (it % 3) == 1, 0);
        end

        sel = 0; set_clean(); vt[2] = TT ^ 16'h8001;
        sweep("extra_start", 1, 0);
        sweep("hold_start", 0, 1);

        // reset while vector 7 is applied
        sel = 0; set_clean();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (o_abcd != 4'd7 && n < 200) begin n++; @(negedge clk); end
        chk("reach_vec7", o_abcd, 7);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_abcd", o_abcd, 0);
        chk("midrst_cnt", o_cnt, 0);
        chk("midrst_done", o_done, 0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (80) begin
            if (o_done || o_busy) seen = 1;
            @(negedge clk);
        end
        chk("midrst_no_done", seen, 0);
        sweep("after_rst", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
